// File: rtl/accel_job_sequencer_pkg.sv
// Shared state encoding, default job geometry and width helpers for the
// accelerator job sequencer.
package accel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_NUM_TILES       = 16;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 65535;

    // Tile index width: never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/accel_job_sequencer_if.sv
// Tile command / completion channel between the job sequencer and the
// compute engine.
interface accel_job_sequencer_if #(
    parameter int unsigned IDX_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDX_W-1:0] cmd_tile_idx;
    logic             done_valid;

    modport master (
        output cmd_valid,
        output cmd_tile_idx,
        input  cmd_ready,
        input  done_valid
    );

    modport slave (
        input  cmd_valid,
        input  cmd_tile_idx,
        output cmd_ready,
        output done_valid
    );
endinterface

// File: rtl/accel_job_sequencer_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and pulses
// expire on the cycle the count sits at LIMIT-1.
module seq_watchdog #(
    parameter int unsigned LIMIT = 65535,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // A clear in the same cycle means activity was seen, so no abort.
    assign expire = en & ~clr & (count == LAST);

endmodule

// File: rtl/accel_job_sequencer.sv
// Runs one job of NUM_TILES tile commands per rising edge of start, tracks
// outstanding tiles, and raises Finish (held) on completion or watchdog abort.
module accel_job_sequencer
    import accel_seq_pkg::*;
#(
    parameter int unsigned NUM_TILES       = DEF_NUM_TILES,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int unsigned IDX_W           = idx_width(NUM_TILES)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    output logic                  Finish,
    output logic                  busy,
    output logic                  err_timeout,
    accel_job_sequencer_if.master cmd
);
    localparam int unsigned      CNT_W = cnt_width(NUM_TILES);
    localparam int unsigned      WD_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_TILES);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    seq_state_t       state, state_n;
    logic [CNT_W-1:0] issued, issued_n;
    logic [CNT_W-1:0] completed, completed_n;
    logic [CNT_W-1:0] outstanding, outstanding_n;
    logic             valid_q, valid_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             err_q, err_n;
    logic             start_d;

    logic start_rise, active, launch, hs, done_eff, hold;
    logic wd_clr, wd_expire;

    assign start_rise = start & ~start_d;
    assign active     = (state == ISSUE) || (state == DRAIN);
    assign launch     = start_rise & ((state == IDLE) || (state == DONE));
    assign hs         = valid_q & cmd.cmd_ready;
    assign done_eff   = active & cmd.done_valid & (outstanding != '0);
    assign hold       = valid_q & ~cmd.cmd_ready;
    assign wd_clr     = hs | (active & cmd.done_valid) | launch;

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk    (aclk),
        .rst_n  (aresetn),
        .en     (active),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        state_n       = state;
        issued_n      = issued;
        completed_n   = completed;
        outstanding_n = outstanding;
        err_n         = err_q;
        valid_n       = 1'b0;
        idx_n         = idx_q;

        case (state)
            IDLE, DONE: begin
                if (launch) begin
                    issued_n      = '0;
                    completed_n   = '0;
                    outstanding_n = '0;
                    err_n         = 1'b0;
                    state_n       = ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                if (hs)       issued_n    = issued + CNT_W'(1);
                if (done_eff) completed_n = completed + CNT_W'(1);
                if (hs && !done_eff)      outstanding_n = outstanding + CNT_W'(1);
                else if (!hs && done_eff) outstanding_n = outstanding - CNT_W'(1);

                if (wd_expire) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else if (completed_n == NUM_C) begin
                    state_n = DONE;
                end else if (issued_n == NUM_C) begin
                    state_n = DRAIN;
                end
            end
        endcase

        // Launch cycle leaves cmd_valid low; an offered command is held
        // unchanged until accepted regardless of the outstanding count.
        if (state == ISSUE && state_n == ISSUE) begin
            if (hold) begin
                valid_n = 1'b1;
            end else begin
                valid_n = (issued_n < NUM_C) && (outstanding_n < MAX_C);
                idx_n   = IDX_W'(issued_n);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            issued      <= '0;
            completed   <= '0;
            outstanding <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            start_d     <= 1'b0;
        end else begin
            state       <= state_n;
            issued      <= issued_n;
            completed   <= completed_n;
            outstanding <= outstanding_n;
            valid_q     <= valid_n;
            idx_q       <= idx_n;
            err_q       <= err_n;
            start_d     <= start;
        end
    end

    assign Finish           = (state == DONE);
    assign busy             = active;
    assign err_timeout      = err_q;
    assign cmd.cmd_valid    = valid_q;
    assign cmd.cmd_tile_idx = idx_q;

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Directed bench: dut_a (4 tiles, 4 outstanding, 32-cycle watchdog) and
// dut_b (4 tiles, 2 outstanding) driven from one linear step sequence.
module tb_accel_job_sequencer;

    logic aclk = 1'b0;
    logic aresetn;
    logic start_a, finish_a, busy_a, err_a;
    logic start_b, finish_b, busy_b, err_b;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    accel_job_sequencer_if #(.IDX_W(2)) ia ();
    accel_job_sequencer_if #(.IDX_W(2)) ib ();

    accel_job_sequencer #(
        .NUM_TILES       (4),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (32),
        .IDX_W           (2)
    ) dut_a (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start_a),
        .Finish      (finish_a),
        .busy        (busy_a),
        .err_timeout (err_a),
        .cmd         (ia)
    );

    accel_job_sequencer #(
        .NUM_TILES       (4),
        .MAX_OUTSTANDING (2),
        .TIMEOUT_CYCLES  (32),
        .IDX_W           (2)
    ) dut_b (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start_b),
        .Finish      (finish_b),
        .busy        (busy_b),
        .err_timeout (err_b),
        .cmd         (ib)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full job on dut_a: done returns 3 cycles after each handshake.
    task automatic run_job_a(input int strobe_len, input int hold);
        start_a         = 1'b1;
        ia.cmd_ready    = 1'b1;
        ia.done_valid   = 1'b0;
        tick();
        chk("launch_finish", 32'(finish_a), 32'd0);
        chk("launch_busy", 32'(busy_a), 32'd1);
        chk("launch_valid", 32'(ia.cmd_valid), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            start_a       = (c < strobe_len);
            ia.done_valid = (c >= 5);
            tick();
            if (c <= 4) begin
                chk("issue_valid", 32'(ia.cmd_valid), 32'd1);
                chk("issue_idx", 32'(ia.cmd_tile_idx), 32'(c - 1));
            end else if (c <= 7) begin
                chk("drain_valid", 32'(ia.cmd_valid), 32'd0);
                chk("drain_finish", 32'(finish_a), 32'd0);
            end else begin
                chk("done_finish", 32'(finish_a), 32'd1);
                chk("done_busy", 32'(busy_a), 32'd0);
            end
        end
        ia.done_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("finish_held", 32'(finish_a), 32'd1);
        end
        chk("job_err", 32'(err_a), 32'd0);
    endtask

    initial begin
        aresetn       = 1'b0;
        start_a       = 1'b0;
        start_b       = 1'b0;
        ia.cmd_ready  = 1'b0;
        ia.done_valid = 1'b0;
        ib.cmd_ready  = 1'b0;
        ib.done_valid = 1'b0;
        #1;
        chk("rst_finish", 32'(finish_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_valid", 32'(ia.cmd_valid), 32'd0);
        chk("rst_idx", 32'(ia.cmd_tile_idx), 32'd0);
        chk("rst_b_valid", 32'(ib.cmd_valid), 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Basic job, then a 2-cycle strobe launched from DONE.
        run_job_a(1, 50);
        run_job_a(2, 10);

        // Engine stalls with a command pending.
        start_a      = 1'b1;
        ia.cmd_ready = 1'b0;
        tick();
        chk("stall_launch_finish", 32'(finish_a), 32'd0);
        start_a = 1'b0;
        tick();
        chk("stall_valid0", 32'(ia.cmd_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_valid", 32'(ia.cmd_valid), 32'd1);
            chk("stall_idx", 32'(ia.cmd_tile_idx), 32'd0);
        end
        ia.cmd_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("resume_idx", 32'(ia.cmd_tile_idx), 32'(k));
        end
        tick();
        chk("stall_drain_valid", 32'(ia.cmd_valid), 32'd0);

        // No completions ever return: watchdog aborts 32 cycles after the last handshake.
        for (int k = 0; k < 31; k++) tick();
        chk("wd_pre_finish", 32'(finish_a), 32'd0);
        chk("wd_pre_busy", 32'(busy_a), 32'd1);
        tick();
        chk("wd_finish", 32'(finish_a), 32'd1);
        chk("wd_err", 32'(err_a), 32'd1);
        chk("wd_valid", 32'(ia.cmd_valid), 32'd0);
        chk("wd_busy", 32'(busy_a), 32'd0);
        tick();
        tick();
        chk("wd_err_sticky", 32'(err_a), 32'd1);

        // New job clears the error; reset mid-DRAIN.
        start_a = 1'b1;
        tick();
        chk("relaunch_err", 32'(err_a), 32'd0);
        chk("relaunch_busy", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_drain_valid", 32'(ia.cmd_valid), 32'd0);
        chk("pre_rst_drain_busy", 32'(busy_a), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_finish", 32'(finish_a), 32'd0);
        chk("async_rst_valid", 32'(ia.cmd_valid), 32'd0);
        chk("async_rst_idx", 32'(ia.cmd_tile_idx), 32'd0);
        #1 aresetn = 1'b1;
        ia.done_valid = 1'b1;
        tick();
        ia.done_valid = 1'b0;
        chk("spurious_busy", 32'(busy_a), 32'd0);
        chk("spurious_finish", 32'(finish_a), 32'd0);
        chk("spurious_valid", 32'(ia.cmd_valid), 32'd0);
        tick();
        run_job_a(1, 5);

        // dut_b: outstanding limit of 2 throttles issue.
        start_b      = 1'b1;
        ib.cmd_ready = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        chk("b_idx0", 32'(ib.cmd_tile_idx), 32'd0);
        chk("b_valid0", 32'(ib.cmd_valid), 32'd1);
        tick();
        chk("b_idx1", 32'(ib.cmd_tile_idx), 32'd1);
        chk("b_valid1", 32'(ib.cmd_valid), 32'd1);
        tick();
        chk("b_throttle", 32'(ib.cmd_valid), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("b_throttle_hold", 32'(ib.cmd_valid), 32'd0);
        end
        ib.done_valid = 1'b1;
        tick();
        chk("b_resume_valid", 32'(ib.cmd_valid), 32'd1);
        chk("b_resume_idx", 32'(ib.cmd_tile_idx), 32'd2);
        tick();
        chk("b_idx3", 32'(ib.cmd_tile_idx), 32'd3);
        chk("b_valid3", 32'(ib.cmd_valid), 32'd1);
        tick();
        chk("b_drain_valid", 32'(ib.cmd_valid), 32'd0);
        chk("b_drain_finish", 32'(finish_b), 32'd0);
        tick();
        ib.done_valid = 1'b0;
        chk("b_finish", 32'(finish_b), 32'd1);
        chk("b_err", 32'(err_b), 32'd0);
        tick();
        chk("b_finish_held", 32'(finish_b), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
